fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the IF/ID pipeline register. Owns the 64-bit PC and drives a
//  single-outstanding req/ready + rvalid instruction-memory interface. Presents instruction_out,
//  pc_out and if_valid to IF/ID, and raises flush_out on a decode-stage branch redirect.
// PARAMETERS
//  XLEN      64       PC / address width
//  ILEN      32       instruction width
//  RESET_PC  64'h0    PC fetched first after reset (bits [1:0] must be 0)
// PORTS
//  clk               in   1     clock, rising edge
//  rst               in   1     reset: asynchronous, active-high
//  stall             in   1     hazard unit: hold IF/ID outputs
//  PCSrcD_Control    in   1     branch/jump taken in ID: redirect fetch
//  pc_branch_target  in   XLEN  redirect target; bits [1:0] forced to 0
//  imem_req          out  1     request valid
//  imem_addr         out  XLEN  request address
//  imem_ready        in   1     request accepted when req & ready
//  imem_rvalid       in   1     response valid
//  imem_rdata        in   ILEN  response instruction
//  instruction_out   out  ILEN  to IF/ID instruction_in
//  pc_out            out  XLEN  to IF/ID pc
//  if_valid          out  1     instruction_out/pc_out hold a real instruction
//  flush_out         out  1     to IF/ID flush; combinational = PCSrcD_Control
// BEHAVIOUR
//  - Reset (async): pc_q=RESET_PC, state=ISSUE, instruction_out=32'h00000013 (NOP), pc_out=0,
//    if_valid=0, hold buffer cleared; imem_req=0 while rst=1.
//  - FSM ISSUE/WAIT/HOLD/DISCARD. At most one request outstanding.
//  - ISSUE: imem_req=1, imem_addr=pc_q; req&ready -> WAIT.
//  - WAIT: on rvalid & !stall: instruction_out<=rdata, pc_out<=pc_q, if_valid<=1, pc_q<=pc_q+4, -> ISSUE.
//    On rvalid & stall: rdata/pc_q into hold buffer, -> HOLD; outputs unchanged.
//  - HOLD: imem_req=0; when stall=0: buffer -> outputs, if_valid<=1, pc_q<=pc_q+4, -> ISSUE.
//  - stall=1 in ISSUE/WAIT without rvalid: no output change; outputs always hold while stall=1.
//  - Redirect (PCSrcD_Control=1) has priority over stall and rvalid, any state:
//    pc_q<=target&~3; instruction_out<=NOP, if_valid<=0 at that edge; hold buffer dropped.
//    ISSUE no accept -> ISSUE (addr switches to target next cycle); ISSUE with accept -> DISCARD;
//    WAIT without rvalid -> DISCARD; WAIT with rvalid -> ISSUE (response dropped); HOLD -> ISSUE.
//  - DISCARD: imem_req=0; next rvalid dropped -> ISSUE. Redirect in DISCARD updates pc_q only.
//  - imem_rvalid ignored in ISSUE and HOLD. pc_q+4 wraps modulo 2^XLEN.
//  - Latency: accept at N, rvalid at N+k -> outputs valid in N+k+1; zero-wait imem gives 1 instr / 2 cycles.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds out ports perf_fetch_cnt[31:0] (+1 per instruction delivered to outputs)
//    and perf_discard_cnt[31:0] (+1 per dropped response or hold buffer); both reset to 0, wrap.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  fetch_pkg: fetch_state_e enum {ISSUE,WAIT,HOLD,DISCARD}, XLEN/ILEN localparams, NOP_INSTR=32'h00000013.
//  Sub-module fetch_pc_gen: pc_q register, +4 incrementer, redirect mux, target alignment.
//  FSM, hold buffer and output registers stay in fetch_stage.
// TESTING
//  1. Release rst, ready=1, rvalid 1 cycle after accept, rdata=32'h00500093 -> imem_addr=0;
//     next cycle instruction_out=00500093, pc_out=0, if_valid=1; next imem_addr=4.
//  2. stall=1 at rvalid, pc_q=8, rdata=32'h11223344 -> outputs hold, imem_req=0; stall=0 ->
//     instruction_out=11223344, pc_out=8, next imem_addr=0xC.
//  3. Redirect in WAIT, target 64'h1234567890ABCDEF -> flush_out=1 that cycle, if_valid=0;
//     next rvalid dropped; next imem_addr=64'h1234567890ABCDEC.
//  4. Redirect + rvalid + stall same cycle -> response dropped, outputs NOP/if_valid=0, ISSUE at target.
//  5. RESET_PC=64'hFFFFFFFFFFFFFFFC -> after first fetch imem_addr wraps to 0.
//  6. rst asserted mid-WAIT -> outputs reset immediately; stale rvalid after release in ISSUE ignored;
//     with FETCH_PERF_EN, counters read 0 after reset and test 3 gives perf_discard_cnt=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter for the fetch stage: +4 advance, redirect to a word-aligned target.
module fetch_pc_gen #(
  parameter int XLEN = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_q
);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Redirect wins over advance; the low two target bits are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= {target[XLEN-1:2], 2'b00};
    end else if (advance) begin
      pc_q <= pc_q + PC_STEP;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem request FSM, stall hold buffer, IF/ID outputs.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_discard_cnt counter ports.
//
// state   | meaning
// ISSUE   | request at pc_q presented, waiting for acceptance
// WAIT    | request accepted, waiting for the response
// HOLD    | response captured during a stall, released when stall drops
// DISCARD | redirect hit an in-flight request; next response is dropped
module fetch_stage #(
  parameter int XLEN = fetch_pkg::XLEN,
  parameter int ILEN = fetch_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            PCSrcD_Control,
  input  logic [XLEN-1:0] pc_branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instruction_out,
  output logic [XLEN-1:0] pc_out,
  output logic            if_valid,
  output logic            flush_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_discard_cnt
`endif
);
  import fetch_pkg::*;

  localparam logic [ILEN-1:0] NOP = ILEN'(NOP_INSTR);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            accept;
  logic            advance;

  assign flush_out = PCSrcD_Control;
  assign imem_req  = (state == ISSUE) && !rst;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;
  assign advance   = !PCSrcD_Control && !stall &&
                     (((state == WAIT) && imem_rvalid) || (state == HOLD));

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .redirect (PCSrcD_Control),
    .target   (pc_branch_target),
    .pc_q     (pc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ISSUE;
      instruction_out <= NOP;
      pc_out          <= '0;
      if_valid        <= 1'b0;
      hold_instr      <= '0;
      hold_pc         <= '0;
    end else if (PCSrcD_Control) begin
      // Redirect overrides stall and any response arriving this cycle.
      instruction_out <= NOP;
      if_valid        <= 1'b0;
      hold_instr      <= '0;
      hold_pc         <= '0;
      case (state)
        ISSUE:   state <= accept ? DISCARD : ISSUE;
        WAIT:    state <= imem_rvalid ? ISSUE : DISCARD;
        HOLD:    state <= ISSUE;
        DISCARD: state <= imem_rvalid ? ISSUE : DISCARD;
        default: state <= ISSUE;
      endcase
    end else begin
      case (state)
        ISSUE: begin
          if (accept) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!stall) begin
              instruction_out <= imem_rdata;
              pc_out          <= pc_q;
              if_valid        <= 1'b1;
              state           <= ISSUE;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc    <= pc_q;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            instruction_out <= hold_instr;
            pc_out          <= hold_pc;
            if_valid        <= 1'b1;
            state           <= ISSUE;
          end
        end
        DISCARD: begin
          if (imem_rvalid) state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic dropped;

  // A response dies either in DISCARD or when a redirect meets it in WAIT; a held one dies on redirect.
  assign dropped = ((state == DISCARD) && imem_rvalid) ||
                   (PCSrcD_Control && (((state == WAIT) && imem_rvalid) || (state == HOLD)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      if (advance) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (dropped) perf_discard_cnt <= perf_discard_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level model of fetch/deliver/drop rules.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        PCSrcD_Control;
  logic [63:0] pc_branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [63:0] pc_out;
  logic        if_valid;
  logic        flush_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_discard_cnt;
`endif

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .PCSrcD_Control   (PCSrcD_Control),
    .pc_branch_target (pc_branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instruction_out  (instruction_out),
    .pc_out           (pc_out),
    .if_valid         (if_valid),
    .flush_out        (flush_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_discard_cnt (perf_discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: next fetch address, in-flight request, pending drop, stall buffer, visible outputs.
  logic [63:0] m_pc, m_opc, m_bpc;
  logic [31:0] m_oi, m_bi;
  logic        m_ov, m_bv, m_out, m_drop;
  int unsigned m_fetches, m_discards;

  // Memory responder: one request in flight, response 1..3 cycles after acceptance.
  logic        mem_busy = 1'b0;
  logic [63:0] mem_addr = '0;
  int          mem_wait = 0;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return (lo * 32'h9E3779B1) ^ a[63:32] ^ 32'h00500093;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_opc = '0; m_bpc = '0;
    m_oi = NOP; m_bi = '0;
    m_ov = 1'b0; m_bv = 1'b0; m_out = 1'b0; m_drop = 1'b0;
    m_fetches = 0; m_discards = 0;
  endtask

  task automatic deliver(input logic [31:0] instr, input logic [63:0] pc);
    m_oi = instr; m_opc = pc; m_ov = 1'b1;
    m_pc = m_pc + 64'd4;
    m_fetches++;
  endtask

  task automatic compare_outputs();
    logic req_m;
    req_m = !m_out && !m_bv;
    check("instruction_out", {32'd0, instruction_out}, {32'd0, m_oi});
    check("pc_out", pc_out, m_opc);
    check("if_valid", {63'd0, if_valid}, {63'd0, m_ov});
    check("imem_req", {63'd0, imem_req}, {63'd0, req_m});
    if (req_m) check("imem_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_EN
    check("perf_fetch_cnt", {32'd0, perf_fetch_cnt}, {32'd0, m_fetches});
    check("perf_discard_cnt", {32'd0, perf_discard_cnt}, {32'd0, m_discards});
`endif
  endtask

  initial begin
    logic        redir, st, rv, rdy, req_m, acc, did_reset;
    logic [63:0] tgt;
    logic [31:0] rd;
    did_reset = 1'b0;
    rst = 1'b1; stall = 1'b0; PCSrcD_Control = 1'b0; pc_branch_target = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_imem_req", {63'd0, imem_req}, 64'd0);
    check("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check("rst_instruction", {32'd0, instruction_out}, {32'd0, NOP});
    check("rst_pc_out", pc_out, 64'd0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      compare_outputs();

      // Asynchronous reset with a request in flight; its response then shows up as a stale rvalid.
      if (i >= 1500 && !did_reset && m_out) begin
        did_reset = 1'b1;
        stall = 1'b0; PCSrcD_Control = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
        mem_busy = 1'b1; mem_wait = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_instruction", {32'd0, instruction_out}, {32'd0, NOP});
        check("async_rst_pc_out", pc_out, 64'd0);
        check("async_rst_if_valid", {63'd0, if_valid}, 64'd0);
        check("async_rst_imem_req", {63'd0, imem_req}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        continue;
      end

      redir = (i == 5) || (i == 40) || ($urandom_range(99) < 6);
      if (i == 5)       tgt = 64'hFFFF_FFFF_FFFF_FFFF;
      else if (i == 40) tgt = 64'h1234_5678_90AB_CDEF;
      else              tgt = {$urandom, $urandom};
      st  = ($urandom_range(99) < 30);
      rv  = mem_busy && (mem_wait == 0);
      rd  = rv ? mem_data(mem_addr) : $urandom;
      if (!mem_busy && ($urandom_range(99) < 10)) rv = 1'b1;
      rdy = !mem_busy && ($urandom_range(99) < 70);

      stall = st; PCSrcD_Control = redir; pc_branch_target = tgt;
      imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
      #1 check("flush_out", {63'd0, flush_out}, {63'd0, redir});

      req_m = !m_out && !m_bv;
      acc   = req_m && rdy;

      if (mem_busy && mem_wait == 0) mem_busy = 1'b0;
      else if (mem_busy)             mem_wait--;
      if (acc) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_wait = $urandom_range(2);
      end

      if (redir) begin
        m_oi = NOP; m_ov = 1'b0;
        if (m_bv) m_discards++;
        m_bv = 1'b0;
        m_pc = {tgt[63:2], 2'b00};
        if (acc) begin
          m_out = 1'b1; m_drop = 1'b1;
        end else if (m_out && rv) begin
          m_out = 1'b0; m_drop = 1'b0; m_discards++;
        end else if (m_out) begin
          m_drop = 1'b1;
        end
      end else if (acc) begin
        m_out = 1'b1; m_drop = 1'b0;
      end else if (m_out && rv) begin
        m_out = 1'b0;
        if (m_drop) begin
          m_drop = 1'b0; m_discards++;
        end else if (!st) begin
          deliver(rd, m_pc);
        end else begin
          m_bv = 1'b1; m_bi = rd; m_bpc = m_pc;
        end
      end else if (m_bv && !st) begin
        m_bv = 1'b0;
        deliver(m_bi, m_bpc);
      end
    end

    @(negedge clk);
    compare_outputs();
    if (!did_reset) check("mid_run_reset_reached", 64'd0, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
